// File: rtl/coef_pkg.sv
// Shared constants and the readback state encoding for the FIR coefficient loader/readback pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package coef_pkg;

  // Coefficient bank geometry, shared by the loader and the readback transmitter.
  localparam int N_COEF = 16;
  localparam int COEF_W = 12;  // legal range 9..16

  // Frame framing byte, sent ahead of the coefficient bytes.
  localparam logic [7:0] HDR_BYTE = 8'hC5;

  // Index counter width and total frame length (header + hi/lo per coef + checksum).
  localparam int IDX_W       = $clog2(N_COEF);
  localparam int FRAME_BYTES = 2 * N_COEF + 2;

  // Readback FSM encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CHK  = 3'd4
  } rb_state_e;

endpackage

// File: rtl/coef_readback_tx.sv
// Streams a snapshot of the FIR coefficient bank as a framed byte sequence (HDR, hi/lo x N, CHK).
// Latency: busy/valid rise one cycle after an accepted start; one byte per cycle with ready held high.
// Backpressure: tx_ready_i low holds tx_data_o/tx_valid_o stable until the byte is taken.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset; aborts any frame in flight (no done pulse)
//   start_i     one-cycle frame request, accepted only while busy_o=0
//   coefs_i     coefficient k at bits [k*COEF_W +: COEF_W], sampled on an accepted start
//   tx_data_o   registered byte towards the UART transmitter
//   tx_valid_o  tx_data_o holds a byte to transfer
//   tx_ready_i  UART transmitter takes the byte on this edge
//   busy_o      frame in progress
//   done_o      one-cycle pulse in the cycle after the checksum byte is taken
module coef_readback_tx
  import coef_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [N_COEF*COEF_W-1:0] coefs_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

  // State
  rb_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q,   idx_d;
  logic [N_COEF*COEF_W-1:0] snap_q,  snap_d;
  logic [7:0]               chk_q,   chk_d;
  logic [7:0]               data_q,  data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q,  busy_d;
  logic                     done_q,  done_d;

  // Datapath helpers
  logic             xfer;
  logic             start_acc;
  logic [IDX_W-1:0] idx_sel;
  logic [COEF_W-1:0] cur_coef;
  logic [7:0]       hi_byte;
  logic [7:0]       lo_byte;
  logic [7:0]       chk_upd;

  assign xfer      = valid_q && tx_ready_i;
  assign start_acc = start_i && !busy_q;

  // The next byte is loaded into data_q on the transfer edge, so the coefficient
  // selected here is the one the *following* byte comes from: coef 0 when leaving
  // HDR, the current coef when leaving HI, and the next coef when leaving LO.
  always_comb begin
    idx_sel = idx_q;
    case (state_q)
      HDR:     idx_sel = '0;
      LO:      idx_sel = idx_q + IDX_W'(1);
      default: idx_sel = idx_q;
    endcase
    cur_coef = snap_q[int'(idx_sel) * COEF_W +: COEF_W];
    hi_byte  = 8'(cur_coef >> 8);
    lo_byte  = cur_coef[7:0];
  end

  // Every coefficient byte passes through data_q exactly once, so folding the
  // outgoing byte in on its transfer yields the XOR of all hi/lo bytes.
  assign chk_upd = chk_q ^ data_q;

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    chk_d   = chk_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          snap_d  = coefs_i;
          chk_d   = 8'h00;
          idx_d   = '0;
          data_d  = HDR_BYTE;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = HDR;
        end
      end

      HDR: begin
        if (xfer) begin
          data_d  = hi_byte;
          state_d = HI;
        end
      end

      HI: begin
        if (xfer) begin
          chk_d   = chk_upd;
          data_d  = lo_byte;
          state_d = LO;
        end
      end

      LO: begin
        if (xfer) begin
          chk_d = chk_upd;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = hi_byte;
            state_d = HI;
          end else begin
            // Checksum byte includes the lo byte going out on this edge.
            data_d  = chk_upd;
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (xfer) begin
          data_d  = 8'h00;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      chk_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_coef_readback_tx.sv
// Self-checking bench for coef_readback_tx: directed scenarios with random ready/coefficients.
// Expected frames come from an arithmetic model of the byte format (hi = c/256, lo = c%256, XOR checksum).
// All driving and sampling happens on the falling clock edge.
module tb_coef_readback_tx;
  import coef_pkg::*;

  logic                     clk_i;
  logic                     rst_i;
  logic                     start_i;
  logic [N_COEF*COEF_W-1:0] coefs_i;
  logic [7:0]               tx_data_o;
  logic                     tx_valid_o;
  logic                     tx_ready_i;
  logic                     busy_o;
  logic                     done_o;

  coef_readback_tx dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .coefs_i    (coefs_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  logic [COEF_W-1:0] cf [N_COEF];
  logic [7:0]        exp_q [$];
  logic [7:0]        got   [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_coefs();
    for (int k = 0; k < N_COEF; k++) coefs_i[k*COEF_W +: COEF_W] = cf[k];
  endtask

  // Reference frame built straight from the byte-format rules.
  task automatic build_exp();
    int v;
    int hi;
    int lo;
    int x;
    exp_q.delete();
    exp_q.push_back(8'hC5);
    x = 0;
    for (int k = 0; k < N_COEF; k++) begin
      v  = int'(cf[k]);
      hi = v / 256;
      lo = v % 256;
      exp_q.push_back(8'(hi));
      exp_q.push_back(8'(lo));
      x = x ^ hi ^ lo;
    end
    exp_q.push_back(8'(x));
  endtask

  // Runs one frame against exp_q. Indices refer to the number of bytes accepted so far;
  // -1 disables the corresponding action.
  task automatic run_frame(input string tag, input bit issue_start, input int pct,
                           input int poke_at, input int start_at, input int rst_at,
                           input bit chain);
    int   cyc;
    int   vcnt;
    int   stall_err;
    int   dcnt;
    bit   seen_done;
    bit   prev_stall;
    bit   pushed;
    bit   ign_chk;
    logic [7:0] prev_data;

    got.delete();
    cyc = 0; vcnt = 0; stall_err = 0; seen_done = 0;
    prev_stall = 0; prev_data = 8'h00; ign_chk = 0;

    if (issue_start) begin
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check({tag, "_busy_rise"},  32'(busy_o),     32'd1);
      check({tag, "_valid_rise"}, 32'(tx_valid_o), 32'd1);
    end

    while (!seen_done && cyc < 2000) begin
      start_i = 1'b0;
      if (done_o) begin
        seen_done = 1;
      end else begin
        if (prev_stall && (tx_data_o !== prev_data || tx_valid_o !== 1'b1)) stall_err++;
        if (tx_valid_o) vcnt++;
        tx_ready_i = (int'($urandom_range(0, 99)) < pct);
        pushed = tx_valid_o && tx_ready_i;
        if (pushed) got.push_back(tx_data_o);
        prev_stall = tx_valid_o && !tx_ready_i;
        prev_data  = tx_data_o;

        if (pushed && rst_at >= 0 && got.size() == rst_at) begin
          rst_i = 1'b1;
          @(negedge clk_i);
          rst_i = 1'b0;
          tx_ready_i = 1'b1;
          check({tag, "_rst_valid"}, 32'(tx_valid_o), 32'd0);
          check({tag, "_rst_busy"},  32'(busy_o),     32'd0);
          dcnt = 0;
          repeat (40) begin
            if (done_o) dcnt++;
            @(negedge clk_i);
          end
          check({tag, "_rst_no_done"}, 32'(dcnt), 32'd0);
          return;
        end
        if (pushed && poke_at >= 0 && got.size() == poke_at) begin
          cf[3] = 12'h123;
          apply_coefs();
        end
        if (pushed && start_at >= 0 && got.size() == start_at) begin
          start_i = 1'b1;
          ign_chk = 1;
        end
        @(negedge clk_i);
        cyc++;
        if (ign_chk) begin
          check({tag, "_busy_after_ign_start"}, 32'(busy_o), 32'd1);
          ign_chk = 0;
        end
      end
    end

    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_end_busy"},  32'(busy_o),     32'd0);
    check({tag, "_end_valid"}, 32'(tx_valid_o), 32'd0);
    check({tag, "_nbytes"},    32'(got.size()), 32'(FRAME_BYTES));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    end
    check({tag, "_stable_under_stall"}, 32'(stall_err), 32'd0);
    if (pct >= 100) check({tag, "_valid_cycles"}, 32'(vcnt), 32'(FRAME_BYTES));

    if (chain) start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
    if (chain) begin
      check({tag, "_chain_valid"}, 32'(tx_valid_o), 32'd1);
      check({tag, "_chain_hdr"},   32'(tx_data_o),  32'hC5);
      check({tag, "_chain_busy"},  32'(busy_o),     32'd1);
    end
    tx_ready_i = 1'b1;
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    tx_ready_i = 1'b0;
    coefs_i    = '0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(tx_valid_o), 32'd0);
    check("rst_data",  32'(tx_data_o),  32'h00);
    check("rst_busy",  32'(busy_o),     32'd0);
    check("rst_done",  32'(done_o),     32'd0);
    rst_i = 1'b0;
    tx_ready_i = 1'b1;
    @(negedge clk_i);

    // T1 nominal
    for (int k = 0; k < N_COEF; k++) cf[k] = '0;
    cf[3] = 12'hABC;
    apply_coefs();
    build_exp();
    run_frame("t1", 1, 100, -1, -1, -1, 0);
    if (got.size() == FRAME_BYTES) begin
      check("t1_hi3",  32'(got[7]),  32'h0A);
      check("t1_lo3",  32'(got[8]),  32'hBC);
      check("t1_chk",  32'(got[33]), 32'hB6);
    end

    // T2 all ones
    for (int k = 0; k < N_COEF; k++) cf[k] = 12'hFFF;
    apply_coefs();
    build_exp();
    run_frame("t2", 1, 100, -1, -1, -1, 0);
    if (got.size() == FRAME_BYTES) begin
      check("t2_hi0", 32'(got[1]),  32'h0F);
      check("t2_lo0", 32'(got[2]),  32'hFF);
      check("t2_chk", 32'(got[33]), 32'h00);
    end

    // T3 backpressure, ~30% ready
    for (int k = 0; k < N_COEF; k++) cf[k] = '0;
    cf[3] = 12'hABC;
    apply_coefs();
    build_exp();
    run_frame("t3", 1, 30, -1, -1, -1, 0);

    // T4 snapshot: coef3 rewritten mid-frame
    build_exp();
    run_frame("t4a", 1, 100, 4, -1, -1, 0);
    build_exp();
    run_frame("t4b", 1, 100, -1, -1, -1, 0);
    if (got.size() == FRAME_BYTES) begin
      check("t4b_hi3", 32'(got[7]),  32'h01);
      check("t4b_lo3", 32'(got[8]),  32'h23);
      check("t4b_chk", 32'(got[33]), 32'h22);
    end

    // T5 start rules on random coefficients: ignored mid-frame, accepted in done cycle
    for (int k = 0; k < N_COEF; k++) cf[k] = COEF_W'($urandom);
    apply_coefs();
    build_exp();
    run_frame("t5a", 1, 100, -1, 10, -1, 1);
    run_frame("t5b", 0, 100, -1, -1, -1, 0);

    // Random coefficients under random backpressure
    for (int k = 0; k < N_COEF; k++) cf[k] = COEF_W'($urandom);
    apply_coefs();
    build_exp();
    run_frame("rnd", 1, int'($urandom_range(20, 80)), -1, -1, -1, 0);

    // T6 reset mid-frame, then a full frame
    build_exp();
    run_frame("t6a", 1, 100, -1, -1, 12, 0);
    run_frame("t6b", 1, 100, -1, -1, -1, 0);
    if (got.size() > 0) check("t6b_first_hdr", 32'(got[0]), 32'hC5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
